// File: rtl/semaforo_peatonal_if.sv
// rtl/semaforo_peatonal_if.sv - vehicle lights, button and pedestrian lamp bundle
interface semaforo_peatonal_if;
  logic       r;
  logic       a;
  logic       v;
  logic       boton;
  logic       camina;
  logic       alto_p;
  logic       solicitud;
  logic [5:0] cuenta;
  logic       falla;

  modport master (
    output r, a, v, boton,
    input  camina, alto_p, solicitud, cuenta, falla
  );

  modport slave (
    input  r, a, v, boton,
    output camina, alto_p, solicitud, cuenta, falla
  );
endinterface

// File: rtl/semaforo_peatonal.sv
// rtl/semaforo_peatonal.sv - pedestrian crossing controller slaved to the vehicle lights
// PEATON_CUENTA_EN builds the cuenta down-counter; otherwise cuenta is tied to 0.
module semaforo_peatonal #(
  parameter int T_CAMINA   = 25,
  parameter int T_PARPADEO = 10,
  parameter int T_MEDIO    = 2
) (
  input logic                 clk,
  input logic                 rst,
  semaforo_peatonal_if.slave  bus
);

  localparam logic [2:0] ESPERA   = 3'd0;
  localparam logic [2:0] CAMINA   = 3'd1;
  localparam logic [2:0] PARPADEO = 3'd2;
  localparam logic [2:0] DESPEJE  = 3'd3;
  localparam logic [2:0] FALLA    = 3'd4;

  localparam logic [5:0] CARGA_CAMINA   = 6'(T_CAMINA - 1);
  localparam logic [5:0] CARGA_PARPADEO = 6'(T_PARPADEO - 1);
  localparam logic [5:0] CARGA_MEDIO    = 6'(T_MEDIO - 1);
  localparam logic [5:0] TOTAL          = 6'(T_CAMINA + T_PARPADEO);

  logic [2:0] estado;
  logic [5:0] fase;
  logic [5:0] medio;
  logic       r_d;
  logic       b1, b2, b3;
  logic       camina_q, alto_q, solicitud_q, falla_q;
  logic       luces_ok, inicio_rojo, flanco, arranque, sigue;

  assign luces_ok    = (bus.r ^ bus.a ^ bus.v) & ~(bus.r & bus.a & bus.v);
  assign inicio_rojo = bus.r & ~r_d;
  assign flanco      = b2 & ~b3;
  assign arranque    = luces_ok && (estado == ESPERA) && inicio_rojo && solicitud_q;
  assign sigue       = luces_ok && bus.r &&
                       ((estado == CAMINA) || ((estado == PARPADEO) && (fase != 6'd0)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado      <= ESPERA;
      fase        <= '0;
      medio       <= '0;
      r_d         <= 1'b0;
      b1          <= 1'b0;
      b2          <= 1'b0;
      b3          <= 1'b0;
      camina_q    <= 1'b0;
      alto_q      <= 1'b1;
      solicitud_q <= 1'b0;
      falla_q     <= 1'b0;
    end else begin
      r_d <= bus.r;
      b1  <= bus.boton;
      b2  <= b1;
      b3  <= b2;
      if (!luces_ok) begin
        estado      <= FALLA;
        fase        <= '0;
        medio       <= '0;
        camina_q    <= 1'b0;
        alto_q      <= 1'b1;
        solicitud_q <= 1'b0;
        falla_q     <= 1'b1;
      end else begin
        case (estado)
          ESPERA: begin
            camina_q <= 1'b0;
            alto_q   <= 1'b1;
            if (arranque) begin
              estado      <= CAMINA;
              solicitud_q <= 1'b0;
              camina_q    <= 1'b1;
              alto_q      <= 1'b0;
              fase        <= CARGA_CAMINA;
            end else if (flanco) begin
              solicitud_q <= 1'b1;
            end
          end
          CAMINA: begin
            if (!bus.r) begin
              estado   <= ESPERA;
              camina_q <= 1'b0;
              alto_q   <= 1'b1;
            end else if (fase == 6'd0) begin
              estado   <= PARPADEO;
              fase     <= CARGA_PARPADEO;
              medio    <= CARGA_MEDIO;
              camina_q <= 1'b0;
            end else begin
              fase <= fase - 6'd1;
            end
          end
          PARPADEO: begin
            if (!bus.r) begin
              estado   <= ESPERA;
              camina_q <= 1'b0;
              alto_q   <= 1'b1;
            end else if (fase == 6'd0) begin
              estado   <= DESPEJE;
              camina_q <= 1'b0;
              alto_q   <= 1'b1;
            end else begin
              fase <= fase - 6'd1;
              // Lamp holds for T_MEDIO cycles, then flips.
              if (medio == 6'd0) begin
                camina_q <= ~camina_q;
                medio    <= CARGA_MEDIO;
              end else begin
                medio <= medio - 6'd1;
              end
            end
          end
          DESPEJE: begin
            camina_q <= 1'b0;
            alto_q   <= 1'b1;
            if (flanco)
              solicitud_q <= 1'b1;
            // Waiting for the red to end stops a second walk in the same red.
            if (!bus.r)
              estado <= ESPERA;
          end
          FALLA: begin
            camina_q    <= 1'b0;
            alto_q      <= 1'b1;
            solicitud_q <= 1'b0;
            falla_q     <= 1'b1;
          end
          default: begin
            estado   <= ESPERA;
            camina_q <= 1'b0;
            alto_q   <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef PEATON_CUENTA_EN
  logic [5:0] cuenta_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cuenta_q <= '0;
    else if (arranque)
      cuenta_q <= TOTAL;
    else if (sigue)
      cuenta_q <= cuenta_q - 6'd1;
    else
      cuenta_q <= '0;
  end

  assign bus.cuenta = cuenta_q;
`else
  assign bus.cuenta = '0;
`endif

  assign bus.camina    = camina_q;
  assign bus.alto_p    = alto_q;
  assign bus.solicitud = solicitud_q;
  assign bus.falla     = falla_q;

endmodule

// File: tb/tb_semaforo_peatonal.sv
// tb/tb_semaforo_peatonal.sv - directed bench for semaforo_peatonal
module tb_semaforo_peatonal;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  semaforo_peatonal_if bus ();

  semaforo_peatonal dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_cuenta(input int val);
`ifdef PEATON_CUENTA_EN
    return val;
`else
    return 0 * val;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic luz(input logic [2:0] rav);
    bus.r = rav[2];
    bus.a = rav[1];
    bus.v = rav[0];
  endtask

  task automatic chk_reposo(input string tag);
    chk({tag, "_camina"}, bus.camina, 0);
    chk({tag, "_alto_p"}, bus.alto_p, 1);
    chk({tag, "_solicitud"}, bus.solicitud, 0);
    chk({tag, "_cuenta"}, bus.cuenta, 0);
    chk({tag, "_falla"}, bus.falla, 0);
  endtask

  task automatic correr(input logic [2:0] rav, input int n, input bit sin_paso);
    luz(rav);
    repeat (n) begin
      tick;
      if (sin_paso) begin
        chk("sin_paso_camina", bus.camina, 0);
        chk("sin_paso_alto_p", bus.alto_p, 1);
        chk("sin_paso_cuenta", bus.cuenta, 0);
      end
    end
  endtask

  task automatic pedir;
    bus.boton = 1'b1;
    repeat (3) tick;
    bus.boton = 1'b0;
    chk("pedir_solicitud", bus.solicitud, 1);
  endtask

  // Full 40-cycle red with a walk expected from its first edge.
  task automatic rojo_con_paseo(input int k_press, input int k_reset);
    int ec, ea, en;
    luz(3'b100);
    for (int k = 0; k < 40; k++) begin
      tick;
      if (k < 25) begin
        ec = 1; ea = 0; en = 35 - k;
      end else if (k < 35) begin
        ec = ((k - 25) / 2) % 2; ea = 0; en = 35 - k;
      end else begin
        ec = 0; ea = 1; en = 0;
      end
      chk("paseo_camina", bus.camina, ec);
      chk("paseo_alto_p", bus.alto_p, ea);
      chk("paseo_cuenta", bus.cuenta, exp_cuenta(en));
      if (k == 0)
        chk("paseo_solicitud_limpia", bus.solicitud, 0);
      if (k == k_press)
        bus.boton = 1'b1;
      if (k == k_press + 3)
        bus.boton = 1'b0;
      if (k == k_reset) begin
        #2 rst = 1'b0;
        #1 chk_reposo("reset_async");
        rst = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    bus.boton = 1'b0;
    luz(3'b001);
    #12;
    chk_reposo("reset");
    rst = 1'b1;
    repeat (3) tick;

    // Press in green, then the real light sequence.
    bus.boton = 1'b1;
    tick; chk("sol_n", bus.solicitud, 0);
    tick; chk("sol_n1", bus.solicitud, 0);
    tick; chk("sol_n2", bus.solicitud, 1);
    bus.boton = 1'b0;
    correr(3'b001, 5, 1'b1);
    correr(3'b010, 3, 1'b1);
    rojo_con_paseo(-1, -1);
    correr(3'b001, 20, 1'b1);
    correr(3'b010, 3, 1'b1);

    // Two full light cycles without a press.
    repeat (2) begin
      correr(3'b100, 40, 1'b1);
      correr(3'b001, 20, 1'b1);
      correr(3'b010, 3, 1'b1);
    end

    // Abort at walk cycle 10.
    pedir;
    luz(3'b100);
    repeat (10) tick;
    chk("abort_pre_camina", bus.camina, 1);
    luz(3'b001);
    tick;
    chk("abort_camina", bus.camina, 0);
    chk("abort_alto_p", bus.alto_p, 1);
    chk("abort_cuenta", bus.cuenta, 0);
    chk("abort_solicitud", bus.solicitud, 0);
    correr(3'b001, 19, 1'b1);
    correr(3'b010, 3, 1'b1);
    correr(3'b100, 40, 1'b1);
    correr(3'b001, 20, 1'b1);

    // Invalid lights during CAMINA.
    pedir;
    luz(3'b100);
    repeat (5) tick;
    chk("falla_pre_camina", bus.camina, 1);
    luz(3'b110);
    tick;
    chk("falla_flag", bus.falla, 1);
    chk("falla_camina", bus.camina, 0);
    chk("falla_alto_p", bus.alto_p, 1);
    chk("falla_cuenta", bus.cuenta, 0);
    luz(3'b001);
    bus.boton = 1'b1;
    repeat (3) tick;
    bus.boton = 1'b0;
    correr(3'b001, 5, 1'b1);
    correr(3'b010, 3, 1'b1);
    correr(3'b100, 40, 1'b1);
    chk("falla_sticky", bus.falla, 1);
    chk("falla_solicitud", bus.solicitud, 0);
    luz(3'b001);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    chk("falla_cleared", bus.falla, 0);

    // Press during CAMINA is ignored.
    pedir;
    correr(3'b010, 3, 1'b1);
    rojo_con_paseo(5, -1);
    chk("ignorada_solicitud", bus.solicitud, 0);
    correr(3'b001, 20, 1'b1);
    correr(3'b010, 3, 1'b1);
    correr(3'b100, 40, 1'b1);
    correr(3'b001, 20, 1'b1);

    // Press during DESPEJE is served at the next red.
    pedir;
    correr(3'b010, 3, 1'b1);
    rojo_con_paseo(35, -1);
    chk("despeje_solicitud", bus.solicitud, 1);
    correr(3'b001, 20, 1'b0);
    correr(3'b010, 3, 1'b0);
    rojo_con_paseo(-1, -1);

    // Press edge coincident with red onset waits one more red.
    correr(3'b001, 20, 1'b1);
    luz(3'b010);
    tick;
    bus.boton = 1'b1;
    tick;
    tick;
    luz(3'b100);
    tick;
    chk("coincide_solicitud", bus.solicitud, 1);
    chk("coincide_camina", bus.camina, 0);
    bus.boton = 1'b0;
    correr(3'b100, 39, 1'b1);
    chk("coincide_sol_retenida", bus.solicitud, 1);
    correr(3'b001, 20, 1'b1);
    correr(3'b010, 3, 1'b1);
    rojo_con_paseo(-1, -1);

    // Asynchronous reset mid-PARPADEO.
    correr(3'b001, 20, 1'b1);
    pedir;
    correr(3'b010, 3, 1'b1);
    rojo_con_paseo(-1, 28);
    tick;
    chk("post_reset_camina", bus.camina, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
